// File: rtl/core_pkg.sv
// Shared encodings for the RV32I memory stage: access sizes, writeback
// source selects and the memory-port FSM states.
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Single-outstanding data-memory port: the stage is master, memory is slave.
interface mem_wb_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_wb_stage_lsu_lane_fmt.sv
// Byte-lane formatting for loads and stores plus alignment check.
module lsu_lane_fmt
  import core_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection, strobes, extension and alignment by access size.
  always_comb begin
    be        = 4'hF;
    wdata     = store_data;
    load_data = rdata;
    misalign  = 1'b0;
    half_s    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    case (funct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
        if (funct3 == F3_B) begin
          load_data = {{24{byte_s[7]}}, byte_s};
        end else begin
          load_data = {24'd0, byte_s};
        end
      end
      F3_H, F3_HU: begin
        be       = 4'b0011 << {addr_lo[1], 1'b0};
        wdata    = {2{store_data[15:0]}};
        misalign = addr_lo[0];
        if (funct3 == F3_H) begin
          load_data = {{16{half_s[15]}}, half_s};
        end else begin
          load_data = {16'd0, half_s};
        end
      end
      default: begin
        misalign = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB register: drives the data-memory port, stalls the
// front end while an access waits, and abandons accesses after a timeout.
module mem_wb_stage
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_wb_stage_if.master dmem,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUresultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RdM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUresultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW
);

  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        access_s, aligned_s, timeout_s, req_s, stall_s;
  logic        misalign_s, buserr_s;
  logic [3:0]  fmt_be_s;
  logic [31:0] fmt_wdata_s, load_data_s;
  logic        fmt_mis_s;

  logic        regwrite_q, regwrite_d;
  logic [1:0]  resultsrc_q, resultsrc_d;
  logic [31:0] alu_q, alu_d, rdata_q, rdata_d, pc4_q, pc4_d;
  logic [4:0]  rd_q, rd_d;

  lsu_lane_fmt u_fmt (
    .funct3     (funct3M),
    .addr_lo    (ALUresultM[1:0]),
    .store_data (WriteDataM),
    .rdata      (dmem.dmem_rdata),
    .be         (fmt_be_s),
    .wdata      (fmt_wdata_s),
    .load_data  (load_data_s),
    .misalign   (fmt_mis_s)
  );

  // FSM state and wait-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: enter WAIT on a missed first cycle, leave on ready or timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (aligned_s && !dmem.dmem_ready) begin
          state_d = WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (dmem.dmem_ready || timeout_s || !aligned_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = WAIT;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs; gated by rst_n so request and stall drop without a clock edge.
  always_comb begin
    access_s   = MemWriteM | (ResultSrcM == RES_MEM);
    aligned_s  = access_s & ~fmt_mis_s;
    timeout_s  = (state_q == WAIT) & (cnt_q == TO_CNT) & ~dmem.dmem_ready;
    req_s      = rst_n & aligned_s & ~timeout_s;
    stall_s    = req_s & ~dmem.dmem_ready;
    misalign_s = rst_n & access_s & fmt_mis_s;
    buserr_s   = rst_n & timeout_s;
  end

  assign dmem.dmem_req   = req_s;
  assign dmem.dmem_we    = req_s & MemWriteM;
  assign dmem.dmem_addr  = word_addr(ALUresultM);
  assign dmem.dmem_wdata = fmt_wdata_s;
  assign dmem.dmem_be    = MemWriteM ? fmt_be_s : 4'hF;
  assign StallM          = stall_s;
  assign MisalignM       = misalign_s;
  assign BusErrM         = buserr_s;

  // MEM/WB next value: bubble while stalled, kill write on fault.
  always_comb begin
    if (!stall_s) begin
      regwrite_d  = RegWriteM & ~misalign_s & ~timeout_s;
      resultsrc_d = ResultSrcM;
      alu_d       = ALUresultM;
      rdata_d     = load_data_s;
      pc4_d       = PCPlus4M;
      rd_d        = RdM;
    end else begin
      regwrite_d  = 1'b0;
      resultsrc_d = resultsrc_q;
      alu_d       = alu_q;
      rdata_d     = rdata_q;
      pc4_d       = pc4_q;
      rd_d        = rd_q;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_q  <= 1'b0;
      resultsrc_q <= 2'b00;
      alu_q       <= 32'd0;
      rdata_q     <= 32'd0;
      pc4_q       <= 32'd0;
      rd_q        <= 5'd0;
    end else begin
      regwrite_q  <= regwrite_d;
      resultsrc_q <= resultsrc_d;
      alu_q       <= alu_d;
      rdata_q     <= rdata_d;
      pc4_q       <= pc4_d;
      rd_q        <= rd_d;
    end
  end

  assign RegWriteW  = regwrite_q;
  assign ResultSrcW = resultsrc_q;
  assign ALUresultW = alu_q;
  assign ReadDataW  = rdata_q;
  assign PCPlus4W   = pc4_q;
  assign RdW        = rd_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed instructions push expected
// responses; a monitor pops and compares as each instruction retires.
module tb_mem_wb_stage;

  localparam int TO = 4;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdv;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } wb_t;

  typedef struct packed {
    logic [3:0] stall;
    logic [3:0] req;
    logic [3:0] mis;
    logic [3:0] berr;
    logic [3:0] bub;
  } cnt_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } strb_t;

  typedef struct {
    wb_t   wb;
    cnt_t  c;
    strb_t s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [31:0] ALUresultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        StallM, MisalignM, BusErrM, RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUresultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;

  logic issue_valid = 1'b0;
  logic done = 1'b0;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_wb_stage_if dif ();

  mem_wb_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dmem       (dif.master),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .funct3M    (funct3M),
    .ALUresultM (ALUresultM),
    .WriteDataM (WriteDataM),
    .PCPlus4M   (PCPlus4M),
    .RdM        (RdM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .ALUresultW (ALUresultW),
    .ReadDataW  (ReadDataW),
    .PCPlus4W   (PCPlus4W),
    .RdW        (RdW)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00; funct3M = 3'b000;
    ALUresultM = 32'd0; WriteDataM = 32'd0; PCPlus4M = 32'd0; RdM = 5'd0;
    dif.dmem_ready = 1'b0; dif.dmem_rdata = 32'd0;
  endtask

  task automatic issue(
    input logic rw, input logic mw, input logic [1:0] rs, input logic [2:0] f3,
    input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4, input logic [4:0] rd,
    input int ncyc, input int rdy_at, input logic [31:0] rword,
    input logic e_rw, input logic [31:0] e_rdv,
    input logic [3:0] e_stall, input logic [3:0] e_req, input logic [3:0] e_mis, input logic [3:0] e_berr,
    input logic e_we, input logic [3:0] e_be, input logic [31:0] e_addr, input logic [31:0] e_wdata);
    exp_t e;
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; funct3M = f3;
    ALUresultM = alu; WriteDataM = wd; PCPlus4M = pc4; RdM = rd;
    e.wb = '{e_rw, rs, alu, e_rdv, pc4, rd};
    e.c  = '{e_stall, e_req, e_mis, e_berr, 4'd0};
    e.s  = '{e_we, e_be, e_addr, e_wdata};
    exp_q.push_back(e);
    issue_valid = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      dif.dmem_ready = (c == rdy_at);
      dif.dmem_rdata = rword;
      @(posedge clk);
      #1;
    end
    issue_valid = 1'b0;
    set_idle();
  endtask

  // Monitor: per-cycle observation, retire-time scoreboard compare, reset checks.
  initial begin : monitor
    logic  pending;
    logic  prev_stall;
    logic  have_strb;
    cnt_t  acc, r_cnt;
    strb_t cap, r_strb;
    exp_t  e;
    wb_t   g;
    pending = 1'b0; prev_stall = 1'b0; have_strb = 1'b0;
    acc = '0; r_cnt = '0; cap = '0; r_strb = '0;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (done) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      if (!rst_n) begin
        checks++;
        if ({dif.dmem_req, StallM, MisalignM, BusErrM, RegWriteW, ResultSrcW, ALUresultW,
             ReadDataW, PCPlus4W, RdW} !== 110'd0) begin
          errors++;
          $display("FAIL reset_state: req=%b stall=%b mis=%b berr=%b rw=%b rs=%b alu=%h rd=%h pc4=%h rdw=%0d, required all 0",
                   dif.dmem_req, StallM, MisalignM, BusErrM, RegWriteW, ResultSrcW, ALUresultW,
                   ReadDataW, PCPlus4W, RdW);
        end
        pending = 1'b0; prev_stall = 1'b0; have_strb = 1'b0; acc = '0;
      end else begin
        if (pending) begin
          pending = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected: retire with empty queue, required an entry");
          end else begin
            e = exp_q.pop_front();
            g = '{RegWriteW, ResultSrcW, ALUresultW, ReadDataW, PCPlus4W, RdW};
            if (g !== e.wb) begin
              errors++;
              $display("FAIL wb_regs: got rw=%b rs=%b alu=%h rdata=%h pc4=%h rd=%0d, required rw=%b rs=%b alu=%h rdata=%h pc4=%h rd=%0d",
                       g.rw, g.rs, g.alu, g.rdv, g.pc4, g.rd,
                       e.wb.rw, e.wb.rs, e.wb.alu, e.wb.rdv, e.wb.pc4, e.wb.rd);
            end
            checks++;
            if (r_cnt !== e.c) begin
              errors++;
              $display("FAIL cycle_counts: got stall=%0d req=%0d mis=%0d berr=%0d bubble_err=%0d, required stall=%0d req=%0d mis=%0d berr=%0d bubble_err=%0d",
                       r_cnt.stall, r_cnt.req, r_cnt.mis, r_cnt.berr, r_cnt.bub,
                       e.c.stall, e.c.req, e.c.mis, e.c.berr, e.c.bub);
            end
            if (e.c.req != 4'd0) begin
              checks++;
              if (r_strb !== e.s) begin
                errors++;
                $display("FAIL strobes: got we=%b be=%b addr=%h wdata=%h, required we=%b be=%b addr=%h wdata=%h",
                         r_strb.we, r_strb.be, r_strb.addr, r_strb.wdata,
                         e.s.we, e.s.be, e.s.addr, e.s.wdata);
              end
            end
          end
        end
        if (issue_valid) begin
          if (StallM)         acc.stall = acc.stall + 4'd1;
          if (MisalignM)      acc.mis   = acc.mis + 4'd1;
          if (BusErrM)        acc.berr  = acc.berr + 4'd1;
          if (prev_stall && RegWriteW) acc.bub = acc.bub + 4'd1;
          if (dif.dmem_req) begin
            acc.req = acc.req + 4'd1;
            if (!have_strb) begin
              cap = '{dif.dmem_we, dif.dmem_be, dif.dmem_addr, dif.dmem_wdata};
              have_strb = 1'b1;
            end
          end
          if (!StallM) begin
            pending = 1'b1;
            r_cnt = acc;
            r_strb = cap;
            acc = '0;
            cap = '0;
            have_strb = 1'b0;
          end
        end
        prev_stall = StallM;
      end
    end
  end

  // Directed stimulus.
  initial begin : stim
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    //    rw    mw    rs     f3      alu          wd            pc4          rd  n  rdy rword          e_rw  e_rdata        st    rq    ms    be    we    be       addr          wdata
    issue(1'b1, 1'b0, 2'b01, 3'b010, 32'h100, 32'h0, 32'h204, 5'd5, 1, 0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0, 4'b1111, 32'h100, 32'h0);
    issue(1'b1, 1'b0, 2'b01, 3'b000, 32'h103, 32'h0, 32'h208, 5'd6, 4, 3, 32'h80112233, 1'b1, 32'hFFFFFF80, 4'd3, 4'd4, 4'd0, 4'd0, 1'b0, 4'b1111, 32'h100, 32'h0);
    issue(1'b1, 1'b0, 2'b01, 3'b100, 32'h103, 32'h0, 32'h20C, 5'd7, 4, 3, 32'h80112233, 1'b1, 32'h00000080, 4'd3, 4'd4, 4'd0, 4'd0, 1'b0, 4'b1111, 32'h100, 32'h0);
    issue(1'b0, 1'b1, 2'b00, 3'b001, 32'h102, 32'h0000ABCD, 32'h210, 5'd0, 1, 0, 32'h0, 1'b0, 32'h0, 4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 4'b1100, 32'h100, 32'hABCDABCD);
    issue(1'b0, 1'b1, 2'b00, 3'b000, 32'h101, 32'h0000005A, 32'h214, 5'd0, 2, 1, 32'h0, 1'b0, 32'h0, 4'd1, 4'd2, 4'd0, 4'd0, 1'b1, 4'b0010, 32'h100, 32'h5A5A5A5A);
    issue(1'b0, 1'b1, 2'b00, 3'b010, 32'h104, 32'hCAFEF00D, 32'h218, 5'd0, 1, 0, 32'h0, 1'b0, 32'h0, 4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 4'b1111, 32'h104, 32'hCAFEF00D);
    issue(1'b1, 1'b0, 2'b01, 3'b001, 32'h102, 32'h0, 32'h21C, 5'd8, 1, 0, 32'h80010000, 1'b1, 32'hFFFF8001, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0, 4'b1111, 32'h100, 32'h0);
    issue(1'b1, 1'b0, 2'b01, 3'b010, 32'h102, 32'h0, 32'h220, 5'd9, 1, -1, 32'h0, 1'b0, 32'h0, 4'd0, 4'd0, 4'd1, 4'd0, 1'b0, 4'b1111, 32'h100, 32'h0);
    issue(1'b1, 1'b0, 2'b01, 3'b010, 32'h400, 32'h0, 32'h224, 5'd10, 5, -1, 32'h0, 1'b0, 32'h0, 4'd4, 4'd4, 4'd0, 4'd1, 1'b0, 4'b1111, 32'h400, 32'h0);
    issue(1'b1, 1'b0, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h228, 5'd11, 1, -1, 32'h0, 1'b1, 32'h0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'b1111, 32'h1234, 32'h0);
    issue(1'b1, 1'b0, 2'b10, 3'b000, 32'h55, 32'h0, 32'h44, 5'd1, 1, -1, 32'h0, 1'b1, 32'h0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'b1111, 32'h54, 32'h0);

    // Abandon a waiting load by reset mid-cycle; no scoreboard entry.
    RegWriteM = 1'b1; ResultSrcM = 2'b01; funct3M = 3'b010; ALUresultM = 32'h300;
    PCPlus4M = 32'h300; RdM = 5'd12;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #10;
    set_idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b1, 1'b0, 2'b01, 3'b010, 32'h200, 32'h0, 32'h304, 5'd13, 3, 2, 32'h12345678, 1'b1, 32'h12345678, 4'd2, 4'd3, 4'd0, 4'd0, 1'b0, 4'b1111, 32'h200, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    done = 1'b1;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline register of the pipelined RV32I core. It consumes the EX/MEM register outputs and drives a single-outstanding req/ready data-memory port with byte-lane formatting.
- It stalls the front of the pipeline while an access waits, and enforces a wait-cycle timeout.
- It registers everything the writeback mux needs.

Parameters:
- TIMEOUT_CYCLES, 16, wait cycles after the first request cycle before an access is abandoned (min 1).
- CNT_W, 5, width of the wait counter (holds TIMEOUT_CYCLES).

Ports:
- clk in 1: clock, rising edge
- rst_n in 1: asynchronous active-low reset
- RegWriteM in 1: register write enable from EX/MEM
- MemWriteM in 1: store
- ResultSrcM in 2: 00 ALU, 01 load data, 10 PC+4; 01 marks a load
- funct3M in 3: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- ALUresultM in 32: effective address / ALU result
- WriteDataM in 32: store data
- PCPlus4M in 32: link value
- RdM in 5: destination register
- dmem_req out 1: access request
- dmem_we out 1: write strobe
- dmem_addr out 32: word address ({ALUresultM[31:2],2'b00})
- dmem_wdata out 32: lane-replicated store data
- dmem_be out 4: byte enables
- dmem_rdata in 32: read word
- dmem_ready in 1: completion, same cycle as rdata
- StallM out 1: freeze PC, IF/ID, ID/EX, EX/MEM
- MisalignM out 1: misaligned-access pulse
- BusErrM out 1: timeout pulse
- RegWriteW out 1, ResultSrcW out 2, ALUresultW out 32, ReadDataW out 32, PCPlus4W out 32, RdW out 5: MEM/WB register

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values:
  - All W outputs are 0. MisalignM and BusErrM are 0.
  - State is IDLE and the counter is 0.
  - dmem_req and StallM go low immediately, without waiting for a clock edge.
- Access detection: access = MemWriteM | (ResultSrcM==01).
- Misalignment:
  - H/HU/SH with addr[0]=1 is misaligned.
  - W/SW with addr[1:0]!=0 is misaligned.
  - A misaligned access never raises dmem_req and never stalls. MisalignM=1 for that cycle, and the instruction enters MEM/WB with RegWriteW=0.
- Store formatting:
  - SB: wdata = {4{byte}}, be = 0001<<addr[1:0].
  - SH: wdata = {2{half}}, be = 0011<<{addr[1],1'b0}.
  - SW: be = 1111.
  - Loads use be = 1111 and dmem_we = 0.
- Load formatting:
  - Byte lane is addr[1:0]; half lane is addr[1].
  - B/H sign-extend; BU/HU zero-extend.
  - The formatted value is registered into ReadDataW.
- FSM has two states, IDLE and WAIT:
  - IDLE, aligned access:
    - dmem_req=1 combinationally from the M inputs.
    - If dmem_ready=1: zero-wait completion, StallM=0, MEM/WB loads at the next edge.
    - Otherwise StallM=1, go to WAIT, counter=1.
  - WAIT:
    - dmem_req stays high and addr/we/be/wdata stay stable (M inputs are held by the stall).
    - On dmem_ready: StallM=0 that cycle, MEM/WB loads, state returns to IDLE, counter clears.
    - Otherwise the counter increments.
    - When the counter == TIMEOUT_CYCLES without ready: BusErrM=1 for one cycle, dmem_req drops, StallM=0, the instruction enters MEM/WB with RegWriteW=0, state returns to IDLE.
  - The stall equation is StallM = aligned_access & ~dmem_ready & ~timeout.
- MEM/WB register:
  - Loads when StallM=0.
  - While StallM=1 it loads a bubble: RegWriteW=0, other W fields hold, so the register file never sees a duplicate write.
- Non-access instructions pass through with one-cycle latency and do not stall.
- Upstream hazard unit: a late dmem_ready in the same cycle as a stall is legal.
- Reset mid-WAIT abandons the access with no pulse on BusErrM.

Decomposition:
- Shared package core_pkg:
  - funct3 size constants.
  - ResultSrc encodings (RES_ALU, RES_MEM, RES_PC4).
  - mem_state_t enum {IDLE, WAIT}.
- Sub-module lsu_lane_fmt (combinational):
  - Inputs: funct3, addr[1:0], store data, read word.
  - Outputs: be, wdata, extended load data, misalign.
- The FSM, counter and MEM/WB register stay in mem_wb_stage.

Test Plan:
- LW at 0x100, ready same cycle, rdata=0xDEADBEEF -> StallM never high; next edge ReadDataW=0xDEADBEEF, ResultSrcW=01, RegWriteW=1.
- LB at 0x103, rdata=0x80112233, ready after 3 cycles -> StallM high 3 cycles with RegWriteW=0 bubbles; then ReadDataW=0xFFFFFF80. LBU same -> 0x00000080.
- SH at 0x102, data 0x0000ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1; SB at 0x101 data 0x5A -> be=0010, wdata=0x5A5A5A5A.
- LW at 0x102 -> dmem_req stays 0, MisalignM pulses 1 cycle, RegWriteW=0, no stall.
- LW, ready never asserted, TIMEOUT_CYCLES=4 -> StallM high 4 cycles, BusErrM pulse, req drops, RegWriteW=0, FSM back to IDLE; next ADD passes normally.
- rst_n low during WAIT -> dmem_req/StallM drop asynchronously, W outputs 0; after release an LW completes normally.
